st1: RTL and testbench

ST1 -- requirements
Module: st1

---
 rtl/st1.sv | 139 +++++++++++++
 tb/tb_st1.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/st1.sv
// Execute-stage operand/control register: steers operands to the ALU, shifter or data memory.
// Optional shifter path is compiled in with ST1_SHIFT_OP_EN.
module st1 (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_ex,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] imm,
    input  logic [6:0]  control_in,
    input  logic [31:0] mem_data_read_in,
    output logic        mem_data_wr_en,
    output logic [31:0] mem_data_write_out,
    output logic [31:0] aluin1,
    output logic [31:0] aluin2,
    output logic [2:0]  operation_out,
    output logic [2:0]  opselect_out,
    output logic        enable_arith,
    output logic        enable_shift,
    output logic [4:0]  shift_number
);

    localparam int unsigned DataW  = 32;
    localparam int unsigned OpW    = 3;
    localparam int unsigned ShamtW = 5;

    typedef enum logic [OpW-1:0] {
        OPSEL_SHIFT = 3'b000,
        OPSEL_ARITH = 3'b010,
        OPSEL_MEM   = 3'b100
    } opsel_e;

    logic [OpW-1:0] opsel_in;
    logic           immp_regn;
    logic [OpW-1:0] oper_in;

    assign opsel_in  = control_in[6:4];
    assign immp_regn = control_in[3];
    assign oper_in   = control_in[2:0];

    logic [DataW-1:0] aluin1_q, aluin1_d;
    logic [DataW-1:0] aluin2_q, aluin2_d;
    logic [DataW-1:0] wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic [OpW-1:0]   oper_q, oper_d;
    logic [OpW-1:0]   opsel_q, opsel_d;
    logic             en_arith_q, en_arith_d;
`ifdef ST1_SHIFT_OP_EN
    logic             en_shift_q, en_shift_d;
    logic [ShamtW-1:0] shamt_q, shamt_d;
`endif

    // Next-state decode: data fields hold unless the active opselect writes them; strobes default low.
    always_comb begin
        aluin1_d   = aluin1_q;
        aluin2_d   = aluin2_q;
        wr_data_d  = wr_data_q;
        oper_d     = oper_q;
        opsel_d    = opsel_q;
        wr_en_d    = 1'b0;
        en_arith_d = 1'b0;
`ifdef ST1_SHIFT_OP_EN
        shamt_d    = shamt_q;
        en_shift_d = 1'b0;
`endif
        if (enable_ex) begin
            oper_d  = oper_in;
            opsel_d = opsel_in;
            case (opsel_in)
                OPSEL_ARITH: begin
                    aluin1_d   = src1;
                    aluin2_d   = immp_regn ? imm : src2;
                    en_arith_d = 1'b1;
                end
`ifdef ST1_SHIFT_OP_EN
                OPSEL_SHIFT: begin
                    aluin1_d   = src1;
                    shamt_d    = immp_regn ? imm[ShamtW-1:0] : src2[ShamtW-1:0];
                    en_shift_d = 1'b1;
                end
`endif
                OPSEL_MEM: begin
                    if (immp_regn) begin
                        aluin1_d = src1;
                        aluin2_d = mem_data_read_in;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = src2;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aluin1_q   <= '0;
            aluin2_q   <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            oper_q     <= '0;
            opsel_q    <= '0;
            en_arith_q <= 1'b0;
`ifdef ST1_SHIFT_OP_EN
            en_shift_q <= 1'b0;
            shamt_q    <= '0;
`endif
        end else begin
            aluin1_q   <= aluin1_d;
            aluin2_q   <= aluin2_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            oper_q     <= oper_d;
            opsel_q    <= opsel_d;
            en_arith_q <= en_arith_d;
`ifdef ST1_SHIFT_OP_EN
            en_shift_q <= en_shift_d;
            shamt_q    <= shamt_d;
`endif
        end
    end

    assign aluin1             = aluin1_q;
    assign aluin2             = aluin2_q;
    assign mem_data_write_out = wr_data_q;
    assign mem_data_wr_en     = wr_en_q;
    assign operation_out      = oper_q;
    assign opselect_out       = opsel_q;
    assign enable_arith       = en_arith_q;
`ifdef ST1_SHIFT_OP_EN
    assign enable_shift       = en_shift_q;
    assign shift_number       = shamt_q;
`else
    assign enable_shift       = 1'b0;
    assign shift_number       = ShamtW'(0);
`endif

endmodule

// File: tb/tb_st1.sv
// Directed bench for st1; expectations follow the ST1_SHIFT_OP_EN setting of the build.
module tb_st1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_ex;
    logic [31:0] src1, src2, imm, mem_data_read_in;
    logic [6:0]  control_in;
    logic        mem_data_wr_en;
    logic [31:0] mem_data_write_out, aluin1, aluin2;
    logic [2:0]  operation_out, opselect_out;
    logic        enable_arith, enable_shift;
    logic [4:0]  shift_number;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    st1 dut (
        .clk               (clk),
        .reset             (reset),
        .enable_ex         (enable_ex),
        .src1              (src1),
        .src2              (src2),
        .imm               (imm),
        .control_in        (control_in),
        .mem_data_read_in  (mem_data_read_in),
        .mem_data_wr_en    (mem_data_wr_en),
        .mem_data_write_out(mem_data_write_out),
        .aluin1            (aluin1),
        .aluin2            (aluin2),
        .operation_out     (operation_out),
        .opselect_out      (opselect_out),
        .enable_arith      (enable_arith),
        .enable_shift      (enable_shift),
        .shift_number      (shift_number)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".aluin1"}, aluin1, 32'd0);
        chk({tag, ".aluin2"}, aluin2, 32'd0);
        chk({tag, ".wdata"}, mem_data_write_out, 32'd0);
        chk({tag, ".wr_en"}, 32'(mem_data_wr_en), 32'd0);
        chk({tag, ".op"}, 32'(operation_out), 32'd0);
        chk({tag, ".opsel"}, 32'(opselect_out), 32'd0);
        chk({tag, ".shamt"}, 32'(shift_number), 32'd0);
        chk({tag, ".en_a"}, 32'(enable_arith), 32'd0);
        chk({tag, ".en_s"}, 32'(enable_shift), 32'd0);
    endtask

    logic [31:0] exp_a1;

    initial begin
        reset = 1'b1; enable_ex = 1'b0; src1 = '0; src2 = '0; imm = '0;
        control_in = '0; mem_data_read_in = '0;
        step();
        chk_all_zero("reset");

        // ARITH, register operand
        reset = 1'b0; enable_ex = 1'b1;
        src1 = 32'd0; src2 = 32'd7; imm = 32'd5; control_in = 7'b0100000;
        step();
        chk("ar_reg.aluin1", aluin1, 32'd0);
        chk("ar_reg.aluin2", aluin2, 32'd7);
        chk("ar_reg.opsel", 32'(opselect_out), 32'd2);
        chk("ar_reg.op", 32'(operation_out), 32'd0);
        chk("ar_reg.en_a", 32'(enable_arith), 32'd1);

        // ARITH, immediate operand
        src1 = 32'd5; imm = 32'd2; control_in = 7'b0101000;
        step();
        chk("ar_imm.aluin1", aluin1, 32'd5);
        chk("ar_imm.aluin2", aluin2, 32'd2);
        chk("ar_imm.en_a", 32'(enable_arith), 32'd1);
        chk("ar_imm.en_s", 32'(enable_shift), 32'd0);

        // store
        src2 = 32'h1234; control_in = 7'b1000000;
        step();
        chk("st.wr_en", 32'(mem_data_wr_en), 32'd1);
        chk("st.wdata", mem_data_write_out, 32'h1234);
        chk("st.en_a", 32'(enable_arith), 32'd0);
        chk("st.aluin1_hold", aluin1, 32'd5);
        chk("st.aluin2_hold", aluin2, 32'd2);

        // idle edge after store
        enable_ex = 1'b0; src2 = 32'hFFFF;
        step();
        chk("idle.wr_en", 32'(mem_data_wr_en), 32'd0);
        chk("idle.wdata", mem_data_write_out, 32'h1234);
        chk("idle.opsel", 32'(opselect_out), 32'd4);

        // load
        enable_ex = 1'b1; control_in = 7'b1001000; mem_data_read_in = 32'd7;
        step();
        chk("ld.aluin2", aluin2, 32'd7);
        chk("ld.aluin1", aluin1, 32'd5);
        chk("ld.wr_en", 32'(mem_data_wr_en), 32'd0);
        chk("ld.en_a", 32'(enable_arith), 32'd0);
        chk("ld.wdata", mem_data_write_out, 32'h1234);

        // shift by immediate
        src1 = 32'd9; imm = 32'd3; control_in = 7'b0001101;
        step();
        chk("sh.op", 32'(operation_out), 32'd5);
        chk("sh.opsel", 32'(opselect_out), 32'd0);
        chk("sh.en_a", 32'(enable_arith), 32'd0);
`ifdef ST1_SHIFT_OP_EN
        exp_a1 = 32'd9;
        chk("sh.en_s", 32'(enable_shift), 32'd1);
        chk("sh.shamt", 32'(shift_number), 32'd3);
`else
        exp_a1 = 32'd5;
        chk("sh.en_s", 32'(enable_shift), 32'd0);
        chk("sh.shamt", 32'(shift_number), 32'd0);
`endif
        chk("sh.aluin1", aluin1, exp_a1);

`ifdef ST1_SHIFT_OP_EN
        // shift by register operand: only the low five bits of src2
        src2 = 32'hFFFF_FFF4; control_in = 7'b0000010;
        step();
        chk("shr.shamt", 32'(shift_number), 32'd20);
        chk("shr.en_s", 32'(enable_shift), 32'd1);
`endif

        // illegal opselect
        src1 = 32'hDEAD; control_in = 7'b1110011;
        step();
        chk("ill.en_a", 32'(enable_arith), 32'd0);
        chk("ill.en_s", 32'(enable_shift), 32'd0);
        chk("ill.wr_en", 32'(mem_data_wr_en), 32'd0);
        chk("ill.aluin1", aluin1, exp_a1);
        chk("ill.op", 32'(operation_out), 32'd3);
        chk("ill.opsel", 32'(opselect_out), 32'd7);

        // back-to-back stores keep the strobe high
        src2 = 32'hAA; control_in = 7'b1000000;
        step();
        chk("st2a.wr_en", 32'(mem_data_wr_en), 32'd1);
        src2 = 32'hBB;
        step();
        chk("st2b.wr_en", 32'(mem_data_wr_en), 32'd1);
        chk("st2b.wdata", mem_data_write_out, 32'hBB);

        // reset wins over an enabled store
        reset = 1'b1; src2 = 32'h55;
        step();
        chk_all_zero("rst_st");

        // ARITH register after reset with nonzero operation
        reset = 1'b0; src1 = 32'h11; src2 = 32'h10; imm = 32'h99; control_in = 7'b0100111;
        step();
        chk("ar2.aluin1", aluin1, 32'h11);
        chk("ar2.aluin2", aluin2, 32'h10);
        chk("ar2.op", 32'(operation_out), 32'd7);
        chk("ar2.wr_en", 32'(mem_data_wr_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
